pic_ctrl: RTL and testbench

PIC_CTRL -- requirements
Module: pic_ctrl

---
 rtl/pic_pkg.sv | 27 ++
 rtl/pic_ctrl.sv | 137 +++++++++++++
 tb/tb_pic_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/pic_pkg.sv
// Shared definitions for the PIC command/status port block.
// Holds the init FSM state encoding, the OCW2 EOI command codes, the reset
// vector base and the read-select encoding used by pic_ctrl.
package pic_pkg;

    // Init sequence states: ICW1 can arrive in any state, the rest are ordered.
    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_ICW2  = 2'd1,
        ST_ICW3  = 2'd2,
        ST_ICW4  = 2'd3
    } pic_state_t;

    // OCW2 command field (data bits 7:5).
    localparam logic [2:0] OCW2_EOI  = 3'b001;   // non-specific EOI
    localparam logic [2:0] OCW2_SEOI = 3'b011;   // specific EOI, level in bits 2:0

    // Vector 8 base: lets an unprogrammed system still take sane vectors.
    localparam logic [4:0] VEC_BASE_RST = 5'b00001;

    // Read select for port A0=0 reads.
    typedef enum logic {
        RSEL_IRR = 1'b0,
        RSEL_ISR = 1'b1
    } rsel_t;

endpackage

// File: rtl/pic_ctrl.sv
// Purpose: 8259-style PIC register block: ICW1-4 init FSM, OCW1 mask, OCW2 EOI, OCW3 read select.
// Latency: writes take effect on the next clock; read data and EOI pulses appear one cycle after the strobe.
// Backpressure: none; every strobe is accepted in the cycle it is asserted.
//
// Ports:
//   iClk, iRst          clock, synchronous active-high reset
//   iWr, iRd, iA0       one-cycle write/read strobes and port address bit 0
//   iData               CPU write data
//   iIrr, iIsr          live pending / in-service vectors from the interrupt core
//   oMask               interrupt mask register (1 = masked)
//   oEoi, oEoiSpec,     end-of-interrupt pulse, specific flag and level
//   oEoiLvl
//   oVecBase            vector bits 7:3 for the INTA cycle
//   oSel, oData         read-data-valid strobe and read-back data
module pic_ctrl
    import pic_pkg::*;
(
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iWr,
    input  logic       iRd,
    input  logic       iA0,
    input  logic [7:0] iData,
    input  logic [7:0] iIrr,
    input  logic [7:0] iIsr,
    output logic [7:0] oMask,
    output logic       oEoi,
    output logic       oEoiSpec,
    output logic [2:0] oEoiLvl,
    output logic [4:0] oVecBase,
    output logic       oSel,
    output logic [7:0] oData
);

    pic_state_t state, nxt_state;
    rsel_t      rsel, nxt_rsel;
    logic       sngl, nxt_sngl;
    logic       ic4, nxt_ic4;
    logic [7:0] nxt_mask;
    logic [4:0] nxt_vec_base;
    logic       nxt_eoi, nxt_eoi_spec;
    logic [2:0] nxt_eoi_lvl;
    logic       nxt_sel;
    logic [7:0] nxt_data;

    logic       icw1;

    // ICW1 is recognised in every state and restarts the init sequence.
    assign icw1 = iWr && !iA0 && iData[4];

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state    <= ST_READY;
            rsel     <= RSEL_IRR;
            sngl     <= 1'b1;
            ic4      <= 1'b0;
            oMask    <= 8'h00;
            oVecBase <= VEC_BASE_RST;
            oEoi     <= 1'b0;
            oEoiSpec <= 1'b0;
            oEoiLvl  <= 3'd0;
            oSel     <= 1'b0;
            oData    <= 8'h00;
        end else begin
            state    <= nxt_state;
            rsel     <= nxt_rsel;
            sngl     <= nxt_sngl;
            ic4      <= nxt_ic4;
            oMask    <= nxt_mask;
            oVecBase <= nxt_vec_base;
            oEoi     <= nxt_eoi;
            oEoiSpec <= nxt_eoi_spec;
            oEoiLvl  <= nxt_eoi_lvl;
            oSel     <= nxt_sel;
            oData    <= nxt_data;
        end
    end

    always_comb begin
        nxt_state    = state;
        nxt_rsel     = rsel;
        nxt_sngl     = sngl;
        nxt_ic4      = ic4;
        nxt_mask     = oMask;
        nxt_vec_base = oVecBase;
        nxt_eoi      = 1'b0;
        nxt_eoi_spec = 1'b0;
        nxt_eoi_lvl  = 3'd0;

        if (icw1) begin
            nxt_sngl  = iData[1];
            nxt_ic4   = iData[0];
            nxt_mask  = 8'h00;
            nxt_rsel  = RSEL_IRR;
            nxt_state = ST_ICW2;
        end else if (iWr && iA0) begin
            unique case (state)
                ST_READY: nxt_mask = iData;
                ST_ICW2: begin
                    nxt_vec_base = iData[7:3];
                    if (!sngl)    nxt_state = ST_ICW3;
                    else if (ic4) nxt_state = ST_ICW4;
                    else          nxt_state = ST_READY;
                end
                ST_ICW3:  nxt_state = ic4 ? ST_ICW4 : ST_READY;
                ST_ICW4:  nxt_state = ST_READY;
                default:  nxt_state = ST_READY;
            endcase
        end else if (iWr && state == ST_READY) begin
            // A0=0 and not ICW1: OCW2 or OCW3 by bits 4:3. Mid-init these are dropped.
            if (iData[4:3] == 2'b00) begin
                if (iData[7:5] == OCW2_EOI) begin
                    nxt_eoi = 1'b1;
                end else if (iData[7:5] == OCW2_SEOI) begin
                    nxt_eoi      = 1'b1;
                    nxt_eoi_spec = 1'b1;
                    nxt_eoi_lvl  = iData[2:0];
                end
            end else if (iData[4:3] == 2'b01 && iData[1]) begin
                nxt_rsel = rsel_t'(iData[0]);
            end
        end
    end

    // Read path uses the current (pre-write) register values, so a write and
    // read in the same cycle return the old contents.
    always_comb begin
        nxt_sel  = iRd;
        nxt_data = 8'h00;
        if (iRd) begin
            if (iA0)                    nxt_data = oMask;
            else if (rsel == RSEL_ISR)  nxt_data = iIsr;
            else                        nxt_data = iIrr;
        end
    end

endmodule

// File: tb/tb_pic_ctrl.sv
// Directed bench for pic_ctrl with scoreboard queues for read data and EOI pulses.
module tb_pic_ctrl;
    import pic_pkg::*;

    logic       iClk = 1'b0;
    logic       iRst = 1'b1;
    logic       iWr  = 1'b0;
    logic       iRd  = 1'b0;
    logic       iA0  = 1'b0;
    logic [7:0] iData = 8'h00;
    logic [7:0] iIrr  = 8'h00;
    logic [7:0] iIsr  = 8'h00;
    logic [7:0] oMask;
    logic       oEoi;
    logic       oEoiSpec;
    logic [2:0] oEoiLvl;
    logic [4:0] oVecBase;
    logic       oSel;
    logic [7:0] oData;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] rd_q[$];
    logic [3:0] eoi_q[$];   // {spec, lvl}

    pic_ctrl dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .iWr     (iWr),
        .iRd     (iRd),
        .iA0     (iA0),
        .iData   (iData),
        .iIrr    (iIrr),
        .iIsr    (iIsr),
        .oMask   (oMask),
        .oEoi    (oEoi),
        .oEoiSpec(oEoiSpec),
        .oEoiLvl (oEoiLvl),
        .oVecBase(oVecBase),
        .oSel    (oSel),
        .oData   (oData)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // All drive tasks start and end at posedge+1 and occupy one clock.
    task automatic wr(input logic a0, input logic [7:0] d, input logic exp_eoi,
                      input logic [3:0] exp_rec);
        if (exp_eoi) eoi_q.push_back(exp_rec);
        iWr = 1'b1; iA0 = a0; iData = d;
        @(posedge iClk); #1;
        iWr = 1'b0; iData = 8'h00;
    endtask

    task automatic rd(input logic a0, input logic [7:0] exp);
        rd_q.push_back(exp);
        iRd = 1'b1; iA0 = a0;
        @(posedge iClk); #1;
        iRd = 1'b0;
    endtask

    task automatic wrrd(input logic a0, input logic [7:0] d, input logic [7:0] exp);
        rd_q.push_back(exp);
        iWr = 1'b1; iRd = 1'b1; iA0 = a0; iData = d;
        @(posedge iClk); #1;
        iWr = 1'b0; iRd = 1'b0; iData = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge iClk); #1;
        end
    endtask

    // Response monitor, sampling on the falling edge.
    always @(negedge iClk) begin
        if (!iRst) begin
            if (oSel) begin
                if (rd_q.size() == 0) chk("rd_unexpected", 8'd0, 8'd1);
                else                  chk("rd_data", oData, rd_q.pop_front());
            end else begin
                chk("rd_idle_data", oData, 8'h00);
            end
            if (oEoi) begin
                if (eoi_q.size() == 0) chk("eoi_unexpected", 8'd0, 8'd1);
                else chk("eoi_spec_lvl", {4'd0, oEoiSpec, oEoiLvl}, {4'd0, eoi_q.pop_front()});
            end else begin
                chk("eoi_idle", {4'd0, oEoiSpec, oEoiLvl}, 8'h00);
            end
        end
    end

    initial begin
        // Reset defaults
        idle(2);
        iRst = 1'b0;
        chk("rst_mask", oMask, 8'h00);
        chk("rst_vecbase", {3'd0, oVecBase}, 8'h01);
        chk("rst_sel", {7'd0, oSel}, 8'h00);
        chk("rst_eoi", {7'd0, oEoi}, 8'h00);
        chk("rst_state", {6'd0, dut.state}, {6'd0, ST_READY});
        rd(1'b1, 8'h00);
        idle(1);

        // Full init sequence with ICW3 and ICW4
        wr(1'b0, 8'h11, 1'b0, 4'h0);
        chk("init_icw2", {6'd0, dut.state}, {6'd0, ST_ICW2});
        wr(1'b1, 8'h08, 1'b0, 4'h0);
        chk("init_icw3", {6'd0, dut.state}, {6'd0, ST_ICW3});
        wr(1'b1, 8'h04, 1'b0, 4'h0);
        chk("init_icw4", {6'd0, dut.state}, {6'd0, ST_ICW4});
        wr(1'b1, 8'h01, 1'b0, 4'h0);
        chk("init_ready", {6'd0, dut.state}, {6'd0, ST_READY});
        chk("init_vecbase", {3'd0, oVecBase}, 8'h01);
        wr(1'b1, 8'hFC, 1'b0, 4'h0);
        chk("init_mask", oMask, 8'hFC);
        rd(1'b1, 8'hFC);

        // Single mode, no ICW4; an OCW2-looking write mid-init is ignored
        wr(1'b0, 8'h12, 1'b0, 4'h0);
        chk("sngl_mask_clr", oMask, 8'h00);
        wr(1'b0, 8'h20, 1'b0, 4'h0);
        chk("sngl_hold_icw2", {6'd0, dut.state}, {6'd0, ST_ICW2});
        wr(1'b1, 8'h70, 1'b0, 4'h0);
        chk("sngl_ready", {6'd0, dut.state}, {6'd0, ST_READY});
        chk("sngl_vecbase", {3'd0, oVecBase}, 8'h0E);
        wr(1'b1, 8'hFE, 1'b0, 4'h0);
        chk("sngl_mask", oMask, 8'hFE);

        // EOI commands
        wr(1'b0, 8'h20, 1'b1, 4'b0_000);
        idle(1);
        wr(1'b0, 8'h64, 1'b1, 4'b1_100);
        idle(1);
        wr(1'b0, 8'hA0, 1'b0, 4'h0);
        idle(2);
        chk("eoi_q_drained", 8'(eoi_q.size()), 8'd0);

        // OCW3 read select
        iIrr = 8'h11; iIsr = 8'h02;
        wr(1'b0, 8'h0B, 1'b0, 4'h0);
        rd(1'b0, 8'h02);
        wr(1'b0, 8'h0A, 1'b0, 4'h0);
        rd(1'b0, 8'h11);
        wr(1'b0, 8'h08, 1'b0, 4'h0);
        rd(1'b0, 8'h11);
        idle(1);

        // Reset mid-sequence, with strobes during the reset cycle ignored
        wr(1'b0, 8'h11, 1'b0, 4'h0);
        chk("rst_mid_icw2", {6'd0, dut.state}, {6'd0, ST_ICW2});
        iRst = 1'b1; iWr = 1'b1; iRd = 1'b1; iA0 = 1'b1; iData = 8'h33;
        @(posedge iClk); #1;
        iRst = 1'b0; iWr = 1'b0; iRd = 1'b0; iData = 8'h00;
        chk("rst_mid_state", {6'd0, dut.state}, {6'd0, ST_READY});
        chk("rst_mid_mask", oMask, 8'h00);
        chk("rst_mid_sel", {7'd0, oSel}, 8'h00);
        chk("rst_mid_vecbase", {3'd0, oVecBase}, 8'h01);
        wr(1'b1, 8'h55, 1'b0, 4'h0);
        chk("ocw1_after_rst", oMask, 8'h55);

        // Simultaneous write and read return the pre-write value
        wrrd(1'b1, 8'hAA, 8'h55);
        chk("collide_mask", oMask, 8'hAA);
        rd(1'b1, 8'hAA);
        idle(3);
        chk("rd_q_drained", 8'(rd_q.size()), 8'd0);
        chk("eoi_q_final", 8'(eoi_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
